// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority-encoder queue.
// Selection modes and an index-to-one-hot helper sized for the largest supported N.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int MAX_N = 256;

  // Callers truncate the result to their own width with a size cast.
  function automatic logic [MAX_N-1:0] idx_to_onehot(input int unsigned idx);
    return {{(MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational wrap-around search: finds the first set bit of vec,
// starting at index start and moving downward (start, start-1, ..., 0, N-1, ...).
module prio_find #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) >= k) ? int'(start) - k : int'(start) + N - k;
      if (!found && pos < N && vec[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/prio_enc_queue.sv
// Sticky request capture with one-index-per-handshake issue, using fixed
// (MSB-highest) or round-robin priority over the masked pending vector.
module prio_enc_queue
  import prio_enc_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int MODE  = MODE_FIXED,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             none_on,
  output logic [N-1:0]     pending
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel;
  logic [N-1:0]     elig;
  logic [N-1:0]     clr;
  logic             found;
  logic             load;

  assign elig  = pending & mask;
  assign start = (MODE == MODE_RR) ? ptr : IDX_W'(N - 1);

  prio_find #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_find (
    .vec   (elig),
    .start (start),
    .idx   (sel),
    .found (found)
  );

  assign load    = (!out_valid || out_ready) && found;
  assign clr     = load ? N'(idx_to_onehot(32'(sel))) : '0;
  assign none_on = !out_valid && !(|elig);

  // A request arriving on the bit being issued re-arms it as a fresh event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= IDX_W'(N - 1);
    end else begin
      pending <= (pending & ~clr) | req;
      if (load) begin
        out_valid <= 1'b1;
        out_idx   <= sel;
        if (MODE == MODE_RR) begin
          ptr <= (sel == '0) ? IDX_W'(N - 1) : sel - 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_queue.sv
// Bench for prio_enc_queue: fixed and round-robin instances share one stimulus
// stream and are checked every cycle against a queue-level model plus literal issue orders.
module tb_prio_enc_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] mask = '0;
  logic       out_ready = 1'b0;

  logic       fix_valid, rr_valid;
  logic [2:0] fix_idx, rr_idx;
  logic       fix_none, rr_none;
  logic [7:0] fix_pend, rr_pend;

  int n_checks = 0;
  int n_fail = 0;
  logic check_en = 1'b0;

  int log_fix[$];
  int log_rr[$];
  int exp_q[$];

  // Model state, index 0 = fixed instance, index 1 = round-robin instance
  logic [7:0] m_pend[2];
  logic       m_valid[2];
  int         m_idx[2];
  int         m_ptr[2];

  always #5 clk = ~clk;

  prio_enc_queue #(.N(8), .MODE(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask),
    .out_valid(fix_valid), .out_ready(out_ready), .out_idx(fix_idx),
    .none_on(fix_none), .pending(fix_pend)
  );

  prio_enc_queue #(.N(8), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask),
    .out_valid(rr_valid), .out_ready(out_ready), .out_idx(rr_idx),
    .none_on(rr_none), .pending(rr_pend)
  );

  function automatic int pick_fixed(input logic [7:0] elig);
    for (int i = 7; i >= 0; i--) if (elig[i]) return i;
    return 0;
  endfunction

  function automatic int pick_rr(input logic [7:0] elig, input int from);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (from - k + 8) % 8;
      if (elig[i]) return i;
    end
    return 0;
  endfunction

  // Model: one issue per handshake slot, chosen by the priority rule; issued bit cleared unless re-requested
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = '0; m_valid[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 7;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        logic [7:0] elig;
        int sel;
        elig = m_pend[m] & mask;
        if ((!m_valid[m] || out_ready) && elig != 0) begin
          sel = (m == 0) ? pick_fixed(elig) : pick_rr(elig, m_ptr[m]);
          m_pend[m]  = (m_pend[m] & ~(8'd1 << sel)) | req;
          m_valid[m] = 1'b1;
          m_idx[m]   = sel;
          m_ptr[m]   = (sel == 0) ? 7 : sel - 1;
        end else begin
          if (m_valid[m] && out_ready) m_valid[m] = 1'b0;
          m_pend[m] = m_pend[m] | req;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkLog(input string name, input int got[$], input int want[$]);
    checkOutput({name, ".count"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++)
      checkOutput($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(want[i]));
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m, input logic rdy);
    @(posedge clk);
    #2;
    req = r;
    mask = m;
    out_ready = rdy;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("fix.valid", 32'(fix_valid), 32'(m_valid[0]));
      checkOutput("fix.idx",   32'(fix_idx),   32'(m_idx[0]));
      checkOutput("fix.pend",  32'(fix_pend),  32'(m_pend[0]));
      checkOutput("fix.none",  32'(fix_none),  32'(!m_valid[0] && (m_pend[0] & mask) == 0));
      checkOutput("rr.valid",  32'(rr_valid),  32'(m_valid[1]));
      checkOutput("rr.idx",    32'(rr_idx),    32'(m_idx[1]));
      checkOutput("rr.pend",   32'(rr_pend),   32'(m_pend[1]));
      checkOutput("rr.none",   32'(rr_none),   32'(!m_valid[1] && (m_pend[1] & mask) == 0));
      if (fix_valid && out_ready) log_fix.push_back(int'(fix_idx));
      if (rr_valid && out_ready) log_rr.push_back(int'(rr_idx));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset.valid", 32'(fix_valid), 32'd0);
    checkOutput("reset.none",  32'(rr_none),   32'd1);

    $display("[TB] fixed burst 7,5,2");
    log_fix.delete(); log_rr.delete();
    applyStimulus(8'hA4, 8'hFF, 1'b1);
    repeat (6) applyStimulus(8'h00, 8'hFF, 1'b1);
    exp_q = '{7, 5, 2};
    checkLog("burst.fix", log_fix, exp_q);
    checkLog("burst.rr", log_rr, exp_q);
    @(negedge clk);
    checkOutput("burst.none", 32'(fix_none), 32'd1);

    $display("[TB] backpressure");
    log_fix.delete(); log_rr.delete();
    applyStimulus(8'h0A, 8'hFF, 1'b0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h00, 8'hFF, 1'b0);
      @(negedge clk);
      checkOutput("hold.idx", 32'(fix_idx), 32'd3);
      checkOutput("hold.valid", 32'(fix_valid), 32'd1);
    end
    repeat (5) applyStimulus(8'h00, 8'hFF, 1'b1);
    exp_q = '{3, 1};
    checkLog("bp.fix", log_fix, exp_q);
    exp_q = '{1, 3};
    checkLog("bp.rr", log_rr, exp_q);

    $display("[TB] mask");
    log_fix.delete(); log_rr.delete();
    applyStimulus(8'h44, 8'h04, 1'b1);
    repeat (4) applyStimulus(8'h00, 8'h04, 1'b1);
    @(negedge clk);
    checkOutput("mask.pend", 32'(fix_pend), 32'h40);
    checkOutput("mask.none", 32'(fix_none), 32'd1);
    repeat (4) applyStimulus(8'h00, 8'hFF, 1'b1);
    exp_q = '{2, 6};
    checkLog("mask.fix", log_fix, exp_q);
    checkLog("mask.rr", log_rr, exp_q);

    $display("[TB] round-robin fairness");
    log_fix.delete(); log_rr.delete();
    repeat (8) applyStimulus(8'h88, 8'hFF, 1'b1);
    repeat (5) applyStimulus(8'h00, 8'hFF, 1'b1);
    exp_q = '{3, 7, 3, 7, 3, 7, 3, 7, 3};
    checkLog("rr.order", log_rr, exp_q);
    exp_q = '{7, 7, 7, 7, 7, 7, 7, 7, 3};
    checkLog("fix.order", log_fix, exp_q);

    $display("[TB] collision");
    log_fix.delete(); log_rr.delete();
    applyStimulus(8'h10, 8'hFF, 1'b1);
    applyStimulus(8'h10, 8'hFF, 1'b1);
    applyStimulus(8'h00, 8'hFF, 1'b1);
    @(negedge clk);
    checkOutput("coll.pend", 32'(fix_pend), 32'h10);
    checkOutput("coll.idx", 32'(rr_idx), 32'd4);
    repeat (4) applyStimulus(8'h00, 8'hFF, 1'b1);
    exp_q = '{4, 4};
    checkLog("coll.fix", log_fix, exp_q);
    checkLog("coll.rr", log_rr, exp_q);

    $display("[TB] reset mid-handshake");
    repeat (3) applyStimulus(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    checkOutput("prerst.pend", 32'(fix_pend), 32'hFF);
    checkOutput("prerst.valid", 32'(fix_valid), 32'd1);
    #1 rst_n = 1'b0;
    req = 8'h00;
    #1;
    checkOutput("rst.fix.valid", 32'(fix_valid), 32'd0);
    checkOutput("rst.fix.idx",   32'(fix_idx),   32'd0);
    checkOutput("rst.fix.pend",  32'(fix_pend),  32'd0);
    checkOutput("rst.fix.none",  32'(fix_none),  32'd1);
    checkOutput("rst.rr.valid",  32'(rr_valid),  32'd0);
    checkOutput("rst.rr.pend",   32'(rr_pend),   32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) applyStimulus(8'h00, 8'hFF, 1'b1);
    @(negedge clk);
    checkOutput("post.none", 32'(rr_none), 32'd1);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
